// File: rtl/fir_serial_pkg.sv
// Shared definitions for the FIR bit-serial link (transmit and receive sides).
package fir_serial_pkg;

    // Default word width and inter-beat idle limit used by both link ends.
    localparam int DEFAULT_LENGTH  = 24;
    localparam int DEFAULT_TIMEOUT = 16;

    // Deserializer control states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/deserializer_fsm.sv
// deserializer_fsm: assembles an LSB-first bit-serial stream into LENGTH-bit
// words and hands them downstream over a valid/ready interface. A partial
// word is dropped if the source goes idle for TIMEOUT enabled cycles.
module deserializer_fsm
    import fir_serial_pkg::*;
#(
    parameter int LENGTH  = DEFAULT_LENGTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_din,
    input  logic              i_din_valid,
    output logic              o_ready,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    input  logic              i_ready,
    output logic              o_abort
);

    localparam int CNT_W = $clog2(LENGTH + 1);
    // A zero-width gap counter is not legal, so keep one bit when the timeout is off.
    localparam int GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LENGTH);
    localparam logic [GAP_W-1:0] GAP_C = GAP_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_next;
    logic [GAP_W-1:0]  w_gap_inc;
    logic [LENGTH-1:0] w_shifted;
    logic [LENGTH-1:0] r_dout;
    logic              r_ready;
    logic              r_dout_valid;
    logic              r_abort;
    logic              w_beat;
    logic              w_load;
    logic              w_abort_next;

    // i_en is applied at the registers; these terms assume an enabled cycle.
    assign w_beat    = i_din_valid && r_ready;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_gap_inc = r_gap + GAP_W'(1);

    // Shift register: w_shifted is the value after accepting i_din this cycle.
    generate
        if (LENGTH == 1) begin : g_single
            assign w_shifted = i_din;
        end else begin : g_multi
            // Bit 0 of the full shift value is discarded on the next shift,
            // so only the upper LENGTH-1 bits need to be stored.
            logic [LENGTH-2:0] r_shift;

            // Accumulate received bits; cleared on reset or when a word is aborted.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_shift <= '0;
                end else if (i_en) begin
                    if (w_abort_next) begin
                        r_shift <= '0;
                    end else if (w_beat) begin
                        r_shift <= w_shifted[LENGTH-1:1];
                    end
                end
            end

            assign w_shifted = {i_din, r_shift};
        end
    endgenerate

    // Next-state, counter and abort decision for the receive FSM.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_gap_next   = r_gap;
        w_load       = 1'b0;
        w_abort_next = 1'b0;
        case (r_state)
            // Idle always holds a zero bit count, so both states share the beat path.
            S_IDLE, S_SHIFT: begin
                if (w_beat) begin
                    // A completing beat wins over any timeout on the same cycle.
                    w_gap_next = '0;
                    if (w_cnt_inc == LEN_C) begin
                        w_state_next = S_OUT;
                        w_cnt_next   = '0;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = S_SHIFT;
                        w_cnt_next   = w_cnt_inc;
                    end
                end else if ((r_state == S_SHIFT) && (TIMEOUT > 0)) begin
                    if (w_gap_inc == GAP_C) begin
                        w_abort_next = 1'b1;
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                        w_gap_next   = '0;
                    end else begin
                        w_gap_next = w_gap_inc;
                    end
                end
            end
            S_OUT: begin
                if (r_dout_valid && i_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_gap_next   = '0;
            end
        endcase
    end

    // State/counter registers and outputs, all derived from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_dout       <= '0;
            r_ready      <= 1'b0;
            r_dout_valid <= 1'b0;
            r_abort      <= 1'b0;
        end else if (i_en) begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_gap        <= w_gap_next;
            r_ready      <= (w_state_next != S_OUT);
            r_dout_valid <= (w_state_next == S_OUT);
            r_abort      <= w_abort_next;
            if (w_load) begin
                r_dout <= w_shifted;
            end
        end
    end

    assign o_ready      = r_ready;
    assign ov_dout      = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_abort      = r_abort;

endmodule

// File: tb/tb_deserializer_fsm.sv
// Self-checking bench for deserializer_fsm (LENGTH=24, TIMEOUT=16).
module tb_deserializer_fsm;

    localparam int LEN = 24;
    localparam int TO  = 16;
    localparam int NW  = 1000;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_en;
    logic           i_din;
    logic           i_din_valid;
    logic           o_ready;
    logic [LEN-1:0] ov_dout;
    logic           o_dout_valid;
    logic           i_ready;
    logic           o_abort;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [LEN-1:0] w;
    int             beats;
    logic           acc_in;
    logic           acc_out;
    logic [LEN-1:0] out_val;
    logic [LEN-1:0] exp_q[$];
    logic [LEN-1:0] exp_word;
    logic [LEN-1:0] cur_word;
    int             bit_idx;
    int             gap_left;
    int             sent;
    int             rcv;
    int             cyc;
    int             abort_cnt;

    deserializer_fsm #(
        .LENGTH (LEN),
        .TIMEOUT(TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_din       (i_din),
        .i_din_valid (i_din_valid),
        .o_ready     (o_ready),
        .ov_dout     (ov_dout),
        .o_dout_valid(o_dout_valid),
        .i_ready     (i_ready),
        .o_abort     (o_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present bits first..last of word, holding each until accepted.
    task automatic send_bits(input logic [LEN-1:0] word, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            int   waited;
            logic acc;
            waited      = 0;
            acc         = 1'b0;
            i_din       = word[i];
            i_din_valid = 1'b1;
            while (!acc) begin
                acc = o_ready && i_en;
                tick();
                waited++;
                if (!acc && waited > 200) begin
                    check("send_accept_timeout", 32'd0, 32'd1);
                    i_din_valid = 1'b0;
                    return;
                end
            end
        end
        i_din_valid = 1'b0;
    endtask

    // Complete the parallel handshake on the word currently presented.
    task automatic drain(input string tag);
        i_ready = 1'b1;
        tick();
        check(tag, {31'd0, o_dout_valid}, 32'd0);
        i_ready = 1'b0;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_en        = 1'b1;
        i_din       = 1'b0;
        i_din_valid = 1'b0;
        i_ready     = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_dv",    {31'd0, o_dout_valid}, 32'd0);
        check("rst_dout",  {8'd0, ov_dout}, 32'd0);
        check("rst_abort", {31'd0, o_abort}, 32'd0);
        i_rst = 1'b0;
        check("rst_ready_pre", {31'd0, o_ready}, 32'd0);
        tick();
        check("rst_ready_rise", {31'd0, o_ready}, 32'd1);

        // Test 1: continuous valid and ready, exactly 24 beats per word
        w           = 24'hA5C3F0;
        i_ready     = 1'b1;
        i_din_valid = 1'b1;
        beats       = 0;
        for (int c = 0; c < 25; c++) begin
            i_din  = (beats < LEN) ? w[beats] : 1'b0;
            acc_in = o_ready && i_din_valid && i_en;
            tick();
            if (acc_in) beats++;
            if (c == LEN - 1) begin
                check("t1_dv",    {31'd0, o_dout_valid}, 32'd1);
                check("t1_dout",  {8'd0, ov_dout}, 32'hA5C3F0);
                check("t1_ready", {31'd0, o_ready}, 32'd0);
            end
        end
        i_din_valid = 1'b0;
        check("t1_beats",    beats, LEN);
        check("t1_dv_pulse", {31'd0, o_dout_valid}, 32'd0);
        check("t1_ready_back", {31'd0, o_ready}, 32'd1);
        check("t1_dout_hold", {8'd0, ov_dout}, 32'hA5C3F0);
        i_ready = 1'b0;

        // Test 2: downstream stall for 10 cycles, next word waits for handshake
        send_bits(24'hA5C3F0, 0, LEN - 1);
        check("t2_dv",   {31'd0, o_dout_valid}, 32'd1);
        check("t2_dout", {8'd0, ov_dout}, 32'hA5C3F0);
        w           = 24'h5A5A5B;
        i_din       = w[0];
        i_din_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t2_hold_dv",    {31'd0, o_dout_valid}, 32'd1);
            check("t2_hold_dout",  {8'd0, ov_dout}, 32'hA5C3F0);
            check("t2_hold_ready", {31'd0, o_ready}, 32'd0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("t2_pbeat_dv",    {31'd0, o_dout_valid}, 32'd0);
        check("t2_pbeat_ready", {31'd0, o_ready}, 32'd1);
        send_bits(w, 0, LEN - 1);
        check("t2_w2_dv",   {31'd0, o_dout_valid}, 32'd1);
        check("t2_w2_dout", {8'd0, ov_dout}, 32'h5A5A5B);
        drain("t2_drain");

        // Test 3: 10 bits then 16 idle cycles abort the partial word
        send_bits(24'h0002B5, 0, 9);
        for (int k = 1; k <= TO; k++) begin
            tick();
            check("t3_abort", {31'd0, o_abort}, {31'd0, (k == TO)});
            check("t3_no_dv", {31'd0, o_dout_valid}, 32'd0);
        end
        tick();
        check("t3_abort_end", {31'd0, o_abort}, 32'd0);
        check("t3_ready",     {31'd0, o_ready}, 32'd1);
        send_bits(24'h000001, 0, LEN - 1);
        check("t3_dv",   {31'd0, o_dout_valid}, 32'd1);
        check("t3_dout", {8'd0, ov_dout}, 32'h000001);
        drain("t3_drain");

        // Test 4: clock enable low mid-word and in the output state
        w = 24'h3C96E1;
        send_bits(w, 0, 7);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t4_gap_abort", {31'd0, o_abort}, 32'd0);
        end
        i_en        = 1'b0;
        i_din_valid = 1'b1;
        i_din       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_en_abort", {31'd0, o_abort}, 32'd0);
            check("t4_en_ready", {31'd0, o_ready}, 32'd1);
        end
        i_din_valid = 1'b0;
        i_en        = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_gap2_abort", {31'd0, o_abort}, 32'd0);
        end
        send_bits(w, 8, LEN - 1);
        check("t4_dv",   {31'd0, o_dout_valid}, 32'd1);
        check("t4_dout", {8'd0, ov_dout}, 32'h3C96E1);
        i_en    = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t4_out_dv",   {31'd0, o_dout_valid}, 32'd1);
            check("t4_out_dout", {8'd0, ov_dout}, 32'h3C96E1);
        end
        i_en = 1'b1;
        tick();
        i_ready = 1'b0;
        check("t4_out_release", {31'd0, o_dout_valid}, 32'd0);

        // Test 5: reset mid-word discards everything
        send_bits(24'h9ABCDE, 0, 11);
        i_rst = 1'b1;
        tick();
        check("t5_ready", {31'd0, o_ready}, 32'd0);
        check("t5_dv",    {31'd0, o_dout_valid}, 32'd0);
        check("t5_dout",  {8'd0, ov_dout}, 32'd0);
        check("t5_abort", {31'd0, o_abort}, 32'd0);
        i_rst = 1'b0;
        tick();
        check("t5_ready_rise", {31'd0, o_ready}, 32'd1);
        send_bits(24'hFFFFFF, 0, LEN - 1);
        check("t5_w_dv",   {31'd0, o_dout_valid}, 32'd1);
        check("t5_w_dout", {8'd0, ov_dout}, 32'hFFFFFF);
        drain("t5_drain");

        // Test 6: random source gaps (below timeout) and random downstream stalls
        cur_word  = LEN'($urandom);
        bit_idx   = 0;
        gap_left  = 0;
        sent      = 0;
        rcv       = 0;
        cyc       = 0;
        abort_cnt = 0;
        while (rcv < NW && cyc < 80000) begin
            if (sent >= NW) begin
                i_din_valid = 1'b0;
            end else if (gap_left > 0) begin
                i_din_valid = 1'b0;
                gap_left--;
            end else begin
                i_din_valid = 1'b1;
                i_din       = cur_word[bit_idx];
            end
            i_ready = ($urandom_range(0, 3) != 0);
            acc_in  = i_en && i_din_valid && o_ready;
            acc_out = i_en && o_dout_valid && i_ready;
            out_val = ov_dout;
            tick();
            cyc++;
            if (o_abort) abort_cnt++;
            if (acc_out) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("rnd_word", {8'd0, out_val}, {8'd0, exp_word});
                end
                rcv++;
            end
            if (acc_in) begin
                bit_idx++;
                if (bit_idx == LEN) begin
                    check("rnd_latency_dv", {31'd0, o_dout_valid}, 32'd1);
                    exp_q.push_back(cur_word);
                    sent++;
                    cur_word = LEN'($urandom);
                    bit_idx  = 0;
                end
                if ($urandom_range(0, 31) == 0) gap_left = $urandom_range(1, TO - 1);
            end
        end
        i_din_valid = 1'b0;
        i_ready     = 1'b0;
        check("rnd_words_received", rcv, NW);
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_no_abort", abort_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
